// File: rtl/port_drain_checker.sv
// port_drain_checker: round-robin drain of four output FIFOs (ports 4..7).
// Each popped word's destination code is checked against the port it came from,
// and the words received on each port are counted.
// Optional feature: define DRAIN_STOP_ON_ERR_EN to halt draining on the first mismatch.
module port_drain_checker #(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              enable,
  input  logic              empty4,
  input  logic              empty5,
  input  logic              empty6,
  input  logic              empty7,
  input  logic [DATA_W-1:0] data4_out,
  input  logic [DATA_W-1:0] data5_out,
  input  logic [DATA_W-1:0] data6_out,
  input  logic [DATA_W-1:0] data7_out,
  output logic              pop4,
  output logic              pop5,
  output logic              pop6,
  output logic              pop7,
  output logic [CNT_W-1:0]  cnt4,
  output logic [CNT_W-1:0]  cnt5,
  output logic [CNT_W-1:0]  cnt6,
  output logic [CNT_W-1:0]  cnt7,
  output logic              error,
  output logic [1:0]        err_port,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HALT   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [3:0]        empty_vec;
  logic [3:0]        pop_q;        // one-hot pop strobe, high in the issue cycle
  logic [1:0]        pop_idx_q;    // port of the strobe currently on pop_q
  logic              rd_pend_q;    // FIFO data for rd_idx_q is valid this cycle
  logic [1:0]        rd_idx_q;
  logic [1:0]        rr_ptr;
  logic [CNT_W-1:0]  cnt_q [4];
  logic              error_q;
  logic [1:0]        err_port_q;

  logic [1:0]        cand;
  logic [1:0]        sel;
  logic              sel_vld;
  logic              issue;
  logic              outstanding;
  logic [1:0]        rd_code;
  logic              mismatch;
  logic              halt_req;

  assign empty_vec   = {empty7, empty6, empty5, empty4};
  // A read is in flight from the strobe cycle until its data has been sampled.
  assign outstanding = (|pop_q) | rd_pend_q;

  // Round-robin pick: first non-empty port at or after rr_ptr.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = rr_ptr + 2'(i);
      if (!sel_vld && !empty_vec[cand]) begin
        sel     = cand;
        sel_vld = 1'b1;
      end
    end
  end

  // Destination code of the word being sampled, and its check.
  always_comb begin
    rd_code = '0;
    case (rd_idx_q)
      2'd0:    rd_code = data4_out[DATA_W-1 -: 2];
      2'd1:    rd_code = data5_out[DATA_W-1 -: 2];
      2'd2:    rd_code = data6_out[DATA_W-1 -: 2];
      default: rd_code = data7_out[DATA_W-1 -: 2];
    endcase
    mismatch = rd_pend_q && (rd_code != rd_idx_q);
`ifdef DRAIN_STOP_ON_ERR_EN
    halt_req = mismatch;
`else
    halt_req = 1'b0;
`endif
  end

  // Payload bits below the destination code are not inspected.
  logic unused_payload;
  assign unused_payload = ^{data4_out[DATA_W-3:0], data5_out[DATA_W-3:0],
                            data6_out[DATA_W-3:0], data7_out[DATA_W-3:0]};

  // Next-state and pop-issue decision.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !init) state_next = ACTIVE;
      end
      ACTIVE: begin
        issue = enable && sel_vld && !init && !halt_req;
        if (halt_req)                     state_next = HALT;
        else if (!enable && !outstanding) state_next = IDLE;
      end
      HALT: begin
        state_next = HALT;
      end
      default: state_next = IDLE;
    endcase
    if (init) state_next = IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Pop strobe, read pipeline, pointer, counters and error capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pop_q      <= '0;
      pop_idx_q  <= '0;
      rd_pend_q  <= 1'b0;
      rd_idx_q   <= '0;
      rr_ptr     <= '0;
      error_q    <= 1'b0;
      err_port_q <= '0;
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (init) begin
      pop_q      <= '0;
      pop_idx_q  <= '0;
      rd_pend_q  <= 1'b0;
      rd_idx_q   <= '0;
      rr_ptr     <= '0;
      error_q    <= 1'b0;
      err_port_q <= '0;
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      pop_q     <= issue ? (4'b0001 << sel) : 4'b0000;
      pop_idx_q <= sel;
      // Data is valid the cycle after the strobe, so the read stage trails pop_q by one.
      rd_pend_q <= |pop_q;
      rd_idx_q  <= pop_idx_q;
      if (issue) rr_ptr <= sel + 2'd1;
      for (int unsigned i = 0; i < 4; i++) begin
        if (rd_pend_q && (rd_idx_q == 2'(i)) && (cnt_q[i] != '1))
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
      if (mismatch && !error_q) begin
        error_q    <= 1'b1;
        err_port_q <= rd_idx_q;
      end
    end
  end

  assign pop4     = pop_q[0];
  assign pop5     = pop_q[1];
  assign pop6     = pop_q[2];
  assign pop7     = pop_q[3];
  assign cnt4     = cnt_q[0];
  assign cnt5     = cnt_q[1];
  assign cnt6     = cnt_q[2];
  assign cnt7     = cnt_q[3];
  assign error    = error_q;
  assign err_port = err_port_q;
  assign busy     = (state == ACTIVE) && (outstanding || !(&empty_vec));

endmodule

// File: tb/tb_port_drain_checker.sv
// Directed bench for port_drain_checker: a default-width instance fed by four
// small FIFO models, plus a CNT_W=3 instance driven directly for saturation.
module tb_port_drain_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic       enable;

  // Main instance
  logic       empty4, empty5, empty6, empty7;
  logic [9:0] dout [4];
  logic       pop4, pop5, pop6, pop7;
  logic [7:0] cnt4, cnt5, cnt6, cnt7;
  logic       error;
  logic [1:0] err_port;
  logic       busy;

  // Saturation instance
  logic       s_empty4;
  logic [9:0] s_data4;
  logic [9:0] s_zero;
  logic       s_pop4, s_pop5, s_pop6, s_pop7;
  logic [2:0] s_cnt4, s_cnt5, s_cnt6, s_cnt7;
  logic       s_error;
  logic [1:0] s_err_port;
  logic       s_busy;

  // FIFO models: words available = loaded - taken, less any strobe already on the wire.
  int         fifo_load  [4];
  int         fifo_taken [4] = '{0, 0, 0, 0};
  logic [9:0] fifo_word  [4];
  logic [3:0] pop_v;

  int n_checks = 0;
  int n_pass   = 0;

  int ev_port[$];
  int ev_cyc[$];
  int last_busy;
  int multi;

  always #5 clk = ~clk;

  assign pop_v  = {pop7, pop6, pop5, pop4};
  assign empty4 = (fifo_load[0] - fifo_taken[0] - int'(pop4)) <= 0;
  assign empty5 = (fifo_load[1] - fifo_taken[1] - int'(pop5)) <= 0;
  assign empty6 = (fifo_load[2] - fifo_taken[2] - int'(pop6)) <= 0;
  assign empty7 = (fifo_load[3] - fifo_taken[3] - int'(pop7)) <= 0;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (pop_v[i]) begin
        dout[i]       <= fifo_word[i];
        fifo_taken[i] <= fifo_taken[i] + 1;
      end
    end
  end

  port_drain_checker u_dut (
    .clk(clk), .reset(reset), .init(init), .enable(enable),
    .empty4(empty4), .empty5(empty5), .empty6(empty6), .empty7(empty7),
    .data4_out(dout[0]), .data5_out(dout[1]), .data6_out(dout[2]), .data7_out(dout[3]),
    .pop4(pop4), .pop5(pop5), .pop6(pop6), .pop7(pop7),
    .cnt4(cnt4), .cnt5(cnt5), .cnt6(cnt6), .cnt7(cnt7),
    .error(error), .err_port(err_port), .busy(busy)
  );

  port_drain_checker #(.DATA_W(10), .CNT_W(3)) u_sat (
    .clk(clk), .reset(reset), .init(init), .enable(enable),
    .empty4(s_empty4), .empty5(1'b1), .empty6(1'b1), .empty7(1'b1),
    .data4_out(s_data4), .data5_out(s_zero), .data6_out(s_zero), .data7_out(s_zero),
    .pop4(s_pop4), .pop5(s_pop5), .pop6(s_pop6), .pop7(s_pop7),
    .cnt4(s_cnt4), .cnt5(s_cnt5), .cnt6(s_cnt6), .cnt7(s_cnt7),
    .error(s_error), .err_port(s_err_port), .busy(s_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Observe n cycles at the falling edge, logging every pop as (port, cycle).
  task automatic watch(input int n);
    ev_port.delete();
    ev_cyc.delete();
    last_busy = -1;
    multi     = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (!$onehot0(pop_v)) multi++;
      for (int p = 0; p < 4; p++) begin
        if (pop_v[p]) begin
          ev_port.push_back(p);
          ev_cyc.push_back(k);
        end
      end
      if (busy) last_busy = k;
    end
  endtask

  task automatic pulse_init();
    @(negedge clk) init = 1'b1;
    @(negedge clk) init = 1'b0;
  endtask

  initial begin
    int bad;
    int found;
    int spops;
    reset    = 1'b0;
    init     = 1'b0;
    enable   = 1'b0;
    s_empty4 = 1'b1;
    s_data4  = 10'h012;
    s_zero   = '0;
    for (int i = 0; i < 4; i++) begin
      fifo_load[i] = 6;
      fifo_word[i] = {i[1:0], 8'h5A};
    end

    // Reset held with all FIFOs non-empty
    repeat (3) @(negedge clk);
    check("rst_pops", 32'(pop_v), 0);
    check("rst_cnt4", 32'(cnt4), 0);
    check("rst_cnt5", 32'(cnt5), 0);
    check("rst_cnt6", 32'(cnt6), 0);
    check("rst_cnt7", 32'(cnt7), 0);
    check("rst_error", 32'(error), 0);
    check("rst_err_port", 32'(err_port), 0);
    check("rst_busy", 32'(busy), 0);

    // Full drain: 6 words per port, strict 4,5,6,7 rotation
    reset  = 1'b1;
    enable = 1'b1;
    watch(40);
    check("drain_pops", ev_port.size(), 24);
    check("drain_multi", multi, 0);
    bad = 0;
    for (int j = 0; j < ev_port.size(); j++) begin
      if (ev_port[j] != (j % 4)) bad++;
      if (ev_cyc[j] != ev_cyc[0] + j) bad++;
    end
    check("drain_order", bad, 0);
    check("drain_busy_fall", last_busy, (ev_cyc.size() > 0) ? ev_cyc[$] + 1 : -99);
    check("drain_cnt4", 32'(cnt4), 6);
    check("drain_cnt5", 32'(cnt5), 6);
    check("drain_cnt6", 32'(cnt6), 6);
    check("drain_cnt7", 32'(cnt7), 6);
    check("drain_error", 32'(error), 0);
    check("drain_busy_end", 32'(busy), 0);

    // init clears counters; then only port 6 has words for 3 cycles
    pulse_init();
    check("init_cnt6", 32'(cnt6), 0);
    check("init_cnt4", 32'(cnt4), 0);
    fifo_load[2] = fifo_load[2] + 3;
    watch(15);
    check("single_pops", ev_port.size(), 3);
    bad = 0;
    for (int j = 0; j < ev_port.size(); j++) if (ev_port[j] != 2) bad++;
    check("single_port", bad, 0);
    check("single_span", (ev_cyc.size() == 3) ? ev_cyc[2] - ev_cyc[0] : -1, 2);
    check("single_cnt6", 32'(cnt6), 3);
    check("single_cnt4", 32'(cnt4), 0);
    check("single_cnt5", 32'(cnt5), 0);
    check("single_cnt7", 32'(cnt7), 0);

    // Mismatch on port 5 (code 2'b10)
    fifo_word[1] = 10'h2A5;
    fifo_load[1] = fifo_load[1] + 1;
    watch(10);
    check("mis_error", 32'(error), 1);
    check("mis_err_port", 32'(err_port), 1);
    check("mis_cnt5", 32'(cnt5), 1);

    // More traffic, including a second bad word on port 7
    fifo_word[3] = 10'h0A5;
    fifo_load[3] = fifo_load[3] + 1;
    fifo_load[0] = fifo_load[0] + 2;
    watch(15);
`ifdef DRAIN_STOP_ON_ERR_EN
    check("halt_pops", ev_port.size(), 0);
    check("halt_cnt4", 32'(cnt4), 0);
    check("halt_cnt7", 32'(cnt7), 0);
`else
    check("cont_pops", ev_port.size(), 3);
    check("cont_cnt4", 32'(cnt4), 2);
    check("cont_cnt7", 32'(cnt7), 1);
`endif
    check("mis2_error", 32'(error), 1);
    check("mis2_err_port", 32'(err_port), 1);

    // Clear, let any leftovers drain, clear again
    pulse_init();
    watch(30);
    pulse_init();
    check("clr_error", 32'(error), 0);
    check("clr_err_port", 32'(err_port), 0);
    check("clr_cnt7", 32'(cnt7), 0);

    // init in the cycle pop7 is high
    fifo_word[3] = 10'h3C1;
    fifo_load[3] = fifo_load[3] + 1;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pop7) begin
        found = 1;
        break;
      end
    end
    check("midinit_found", found, 1);
    init = 1'b1;
    @(negedge clk);
    check("midinit_pop7", 32'(pop7), 0);
    check("midinit_cnt7", 32'(cnt7), 0);
    check("midinit_busy", 32'(busy), 0);
    init = 1'b0;
    watch(4);
    check("midinit_cnt7_late", 32'(cnt7), 0);
    check("midinit_no_pops", ev_port.size(), 0);

    // Reset asserted while a read on port 5 is waiting to be sampled
    fifo_word[1] = 10'h1C2;
    fifo_load[1] = fifo_load[1] + 1;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pop5) begin
        found = 1;
        break;
      end
    end
    check("rstmid_found", found, 1);
    @(negedge clk);
    check("rstmid_busy_before", 32'(busy), 1);
    #2 reset = 1'b0;
    #1;
    check("rstmid_busy_async", 32'(busy), 0);
    check("rstmid_pop5_async", 32'(pop5), 0);
    @(negedge clk) reset = 1'b1;
    watch(6);
    check("rstmid_cnt5", 32'(cnt5), 0);
    check("rstmid_no_pops", ev_port.size(), 0);

    // Saturation: 9 words on port 4 of the CNT_W=3 instance
    spops = 0;
    @(negedge clk) s_empty4 = 1'b0;
    repeat (9) begin
      @(negedge clk);
      if (s_pop4) spops++;
    end
    s_empty4 = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (s_pop4) spops++;
    end
    check("sat_pops", spops, 9);
    check("sat_cnt4", 32'(s_cnt4), 7);
    check("sat_error", 32'(s_error), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/port_drain_checker.md
PORT_DRAIN_CHECKER -- requirements
Module: port_drain_checker

Interface
REQ-001 Parameter DATA_W, default 10, word width; bits [DATA_W-1:DATA_W-2] carry the destination port code.
REQ-002 Parameter CNT_W, default 8, width of each per-port word counter.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and reset.
REQ-004 Port clk, input, 1 bit, rising-edge clock.
REQ-005 Port reset, input, 1 bit, asynchronous active-low reset.
REQ-006 Port init, input, 1 bit, synchronous clear of counters and error, plus return to IDLE.
REQ-007 Port enable, input, 1 bit, permits draining when high.
REQ-008 Ports empty4, empty5, empty6, empty7, input, 1 bit each, output-FIFO empty flags.
REQ-009 Ports data4_out .. data7_out, input, DATA_W each, FIFO read data, valid the cycle after the matching pop.
REQ-010 Ports pop4 .. pop7, output, 1 bit each, FIFO read strobes, registered.
REQ-011 Ports cnt4 .. cnt7, output, CNT_W each, words received per port.
REQ-012 Port error, output, 1 bit, sticky destination-mismatch flag.
REQ-013 Port err_port, output, 2 bits, index (0..3 = port 4..7) of the first mismatch.
REQ-014 Port busy, output, 1 bit, high while in ACTIVE with a read outstanding or any FIFO non-empty.

Function
REQ-015 The FSM SHALL have states IDLE, ACTIVE and HALT.
REQ-016 IDLE -> ACTIVE occurs when enable=1 and init=0; ACTIVE -> IDLE occurs when enable=0 and no read is outstanding.
REQ-017 In ACTIVE, at most one popN SHALL be high per cycle.
- Selection is round-robin starting at rr_ptr.
- The first port from rr_ptr with emptyN=0 is chosen.
- rr_ptr then advances to the chosen index+1, modulo 4.
REQ-018 popN SHALL be asserted only in the cycle the corresponding emptyN=0 is sampled; when all FIFOs are empty, no pop occurs.
REQ-019 Read latency SHALL be 1 cycle: the data of a pop issued in cycle t is sampled in cycle t+1 from dataN_out of the same port.
REQ-020 Sampled word checks:
- Code bits must equal N-4 (port 4 expects 2'b00, port 7 expects 2'b11).
- On a match, cntN increments in cycle t+1.
- On a mismatch, error is set and cntN still increments.
REQ-021 Counters SHALL saturate at 2^CNT_W-1 without wrap.
REQ-022 err_port SHALL record only the first mismatch and hold until reset or init.
REQ-023 When a pop is issued in the same cycle that init=1, the pop SHALL be suppressed, the outstanding read discarded, and the FSM forced to IDLE.
REQ-024 When enable falls with a read outstanding, the read SHALL complete and be checked before the FSM enters IDLE.
REQ-025 busy SHALL be combinational from state, the outstanding-read flag and the empty flags; all other outputs are registered.

Reset
REQ-026 While reset=0, the following SHALL be forced immediately, independent of clk:
- pop4..pop7=0, cnt4..cnt7=0.
- error=0, err_port=0.
- rr_ptr=0, state=IDLE, outstanding-read flag cleared.
REQ-027 When reset asserts mid-read, the pending read SHALL be discarded and not counted.
REQ-028 init=1 SHALL, synchronously, apply the same values as reset except that it does not act asynchronously.

Configuration
REQ-029 Macro DRAIN_STOP_ON_ERR_EN enables halt-on-error.
- Defined: the first mismatch moves the FSM to HALT; HALT issues no pops and exits only via reset or init.
- Undefined: HALT is unreachable and draining continues after a mismatch with error held.

Verification
REQ-030 Reset check: reset=0 at time 0 with empties low -> all pops 0, counters 0, error 0 until reset=1, enable=1.
REQ-031 Full drain: 6 words queued in each FIFO with correct codes, enable=1 -> 24 pops, strictly rotating 4,5,6,7; cnt4..cnt7=6; error=0; busy falls after the last sample.
REQ-032 Single port: only empty6=0 for 3 cycles -> pop6 pulses in 3 consecutive cycles; cnt6=3; the other counters stay 0.
REQ-033 Mismatch: port 5 returns 10'h2A5 (code 2'b10) -> error=1, err_port=1, cnt5 increments.
- With DRAIN_STOP_ON_ERR_EN defined: no further pops occur.
- Without it: draining continues.
REQ-034 Saturation with CNT_W=3: 9 valid words on port 4 -> cnt4 holds at 7.
REQ-035 Mid-operation init: init=1 in the cycle pop7=1 -> pop suppressed, counters 0, state IDLE next cycle, the following data7_out not counted.
